prm_edge_chk_sched: RTL and testbench

//  Shares one combinational bank of prm_oblgc_chk* obstacle checkers between NREQ planner requesters.

---
 rtl/prm_chk_pkg.sv | 37 +++
 rtl/prm_rr_arb.sv | 64 ++++++
 rtl/prm_edge_chk_sched.sv | 170 +++++++++++++++++
 tb/tb_prm_edge_chk_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_chk_pkg.sv
// ============================================================================
// Module      : prm_chk_pkg
// Description : Shared constants, types and helpers for the PRM edge-check
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prm_chk_pkg;

    localparam int CODE_W = 15;

    typedef logic [CODE_W-1:0] chk_code_t;

    // Widest-case view of one reduced result; actual port widths are derived
    // from NREQ/NOBS and are zero-extended into these fields.
    typedef struct packed {
        logic [7:0]  id;
        logic        hit;
        logic [15:0] first;
        logic [16:0] count;
    } chk_rsp_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prm_rr_arb.sv
// ============================================================================
// Module      : prm_rr_arb
// Description : Round-robin arbiter with one-hot grant and rotating pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prm_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  valid_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // First pass scans indices at or above the pointer, second pass wraps.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        if (en_i) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any_o && valid_i[i] && (IDX_W'(i) >= ptr_q)) begin
                    grant_o[i]  = 1'b1;
                    grant_idx_o = IDX_W'(i);
                    grant_any_o = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any_o && valid_i[i]) begin
                    grant_o[i]  = 1'b1;
                    grant_idx_o = IDX_W'(i);
                    grant_any_o = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any_o) begin
            ptr_d = (grant_idx_o == IDX_W'(NREQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prm_edge_chk_sched.sv
// ============================================================================
// Module      : prm_edge_chk_sched
// Description : Shares one obstacle-checker bank between NREQ requesters and
//               queues reduced hit/first/count results in an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prm_edge_chk_sched
    import prm_chk_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int NOBS       = 512,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = (NREQ > 1) ? clog2(NREQ) : 1,
    localparam int FIRST_W    = (NOBS > 1) ? clog2(NOBS) : 1,
    localparam int CNT_W      = clog2(NOBS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CODE_W-1:0]   req_code,
    output logic [NREQ-1:0]          req_ready,
    output logic [CODE_W-1:0]        chk_code,
    input  logic [NOBS-1:0]          chk_mask,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_hit,
    output logic [FIRST_W-1:0]       rsp_first,
    output logic [CNT_W-1:0]         rsp_count,
    output logic                     busy
);

    localparam int FIFO_AW = clog2(FIFO_DEPTH);
    localparam int FCNT_W  = clog2(FIFO_DEPTH + 1);

    logic                credit;
    logic [NREQ-1:0]     grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    chk_code_t           code_sel;

    logic                s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]     s1_id_q, s1_id_d;
    chk_code_t           chk_code_q, chk_code_d;

    logic [FIRST_W-1:0]  red_first;
    logic [CNT_W-1:0]    red_cnt;

    logic [ID_W-1:0]     fifo_id_q    [FIFO_DEPTH];
    logic                fifo_hit_q   [FIFO_DEPTH];
    logic [FIRST_W-1:0]  fifo_first_q [FIFO_DEPTH];
    logic [CNT_W-1:0]    fifo_cnt_q   [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic                push;
    logic                pop;

    // Credit counts the S1 slot so an accepted code always has a FIFO entry.
    assign credit = !rst && ((int'(count_q) + int'(s1_valid_q)) < FIFO_DEPTH);

    prm_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (req_valid),
        .en_i        (credit),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign req_ready = grant;

    always_comb begin
        code_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                code_sel = code_sel | req_code[i*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        s1_valid_d = grant_any;
        s1_id_d    = s1_id_q;
        chk_code_d = chk_code_q;
        if (grant_any) begin
            s1_id_d    = grant_idx;
            chk_code_d = code_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            chk_code_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            chk_code_q <= chk_code_d;
        end
    end

    assign chk_code = chk_code_q;

    // Descending scan leaves the lowest set lane in red_first.
    always_comb begin
        red_first = '0;
        red_cnt   = '0;
        for (int k = NOBS - 1; k >= 0; k--) begin
            if (chk_mask[k]) begin
                red_first = FIRST_W'(k);
            end
        end
        for (int k = 0; k < NOBS; k++) begin
            red_cnt = red_cnt + CNT_W'(chk_mask[k]);
        end
    end

    assign push = s1_valid_q;
    assign pop  = rsp_valid && rsp_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; outputs are masked by rsp_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]    <= s1_id_q;
            fifo_hit_q[wr_ptr_q]   <= (red_cnt != '0);
            fifo_first_q[wr_ptr_q] <= red_first;
            fifo_cnt_q[wr_ptr_q]   <= red_cnt;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q]    : '0;
    assign rsp_hit   = rsp_valid && fifo_hit_q[rd_ptr_q];
    assign rsp_first = rsp_valid ? fifo_first_q[rd_ptr_q] : '0;
    assign rsp_count = rsp_valid ? fifo_cnt_q[rd_ptr_q]   : '0;
    assign busy      = s1_valid_q || rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_prm_edge_chk_sched.sv
// ============================================================================
// Module      : tb_prm_edge_chk_sched
// Description : Scoreboard bench for prm_edge_chk_sched with a modelled
//               checker bank and hand-computed directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prm_edge_chk_sched;
    import prm_chk_pkg::*;

    localparam int NREQ       = 4;
    localparam int NOBS       = 512;
    localparam int FIFO_DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CODE_W-1:0] req_code;
    logic [NREQ-1:0]        req_ready;
    logic [CODE_W-1:0]      chk_code;
    logic [NOBS-1:0]        chk_mask;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic                   rsp_hit;
    logic [8:0]             rsp_first;
    logic [9:0]             rsp_count;
    logic                   busy;

    chk_rsp_t sb[$];
    chk_rsp_t expv[NREQ];
    int       total = 0;
    int       bad   = 0;

    always #5 clk = ~clk;

    prm_edge_chk_sched #(
        .NREQ       (NREQ),
        .NOBS       (NOBS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .chk_code  (chk_code),
        .chk_mask  (chk_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_hit   (rsp_hit),
        .rsp_first (rsp_first),
        .rsp_count (rsp_count),
        .busy      (busy)
    );

    // Checker bank model: 4AFC -> lane 292; else bits 14:12 pick a pattern,
    // bits 8:0 give a lane L (1: lane L only, 2: all ones, 3: lanes >= L).
    function automatic logic [NOBS-1:0] bank(input logic [CODE_W-1:0] c);
        logic [NOBS-1:0] m;
        m = '0;
        if (c == 15'h4AFC) begin
            m[292] = 1'b1;
        end else begin
            case (c[14:12])
                3'd1:    m[c[8:0]] = 1'b1;
                3'd2:    m = '1;
                3'd3:    m = {NOBS{1'b1}} << c[8:0];
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    always_comb chk_mask = bank(chk_code);

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [CODE_W-1:0] c,
                           input logic h, input int f, input int n);
        req_code[CODE_W*i +: CODE_W] = c;
        expv[i] = '{id: 8'(i), hit: h, first: 16'(f), count: 17'(n)};
    endtask

    // One cycle of stimulus: drive valids, check the grant, log expectation.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] g, input string nm);
        @(posedge clk);
        #1;
        req_valid = v;
        #1;
        chk(nm, longint'(req_ready), longint'(g));
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) sb.push_back(expv[i]);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #3;
            if (!busy && !rsp_valid && sb.size() == 0) done = 1'b1;
        end
        chk(nm, longint'(done), 1);
    endtask

    always @(negedge clk) begin : monitor
        chk_rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d first=%0d count=%0d required none",
                         rsp_id, rsp_first, rsp_count);
            end else begin
                e = sb.pop_front();
                chk("rsp_id",    longint'(rsp_id),    longint'(e.id));
                chk("rsp_hit",   longint'(rsp_hit),   longint'(e.hit));
                chk("rsp_first", longint'(rsp_first), longint'(e.first));
                chk("rsp_count", longint'(rsp_count), longint'(e.count));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst       = 1'b1;
        req_valid = '0;
        req_code  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) expv[i] = '0;

        // Reset state, with requests present to show grants are held off.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_rsp_valid", longint'(rsp_valid), 0);
        chk("rst_busy",      longint'(busy),      0);
        chk("rst_chk_code",  longint'(chk_code),  0);
        chk("rst_rsp_count", longint'(rsp_count), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single code, latency 2.
        set_req(0, 15'h4AFC, 1'b1, 292, 1);
        step(4'b0001, 4'b0001, "t1_grant");
        step(4'b0000, 4'b0000, "t1_idle");
        chk("t1_chk_code", longint'(chk_code),  15'h4AFC);
        chk("t1_lat1",     longint'(rsp_valid), 0);
        step(4'b0000, 4'b0000, "t1_idle");
        chk("t1_lat2",     longint'(rsp_valid), 1);
        chk("t1_busy",     longint'(busy),      1);
        step(4'b0000, 4'b0000, "t1_idle");
        chk("t1_popped",   longint'(rsp_valid), 0);
        chk("t1_code_hold", longint'(chk_code), 15'h4AFC);
        chk("t1_not_busy", longint'(busy),      0);

        // All four valid: rotation continues from pointer 1.
        set_req(0, 15'h1005, 1'b1, 5,   1);
        set_req(1, 15'h2000, 1'b1, 0,   512);
        set_req(2, 15'h3100, 1'b1, 256, 256);
        set_req(3, 15'h11FF, 1'b1, 511, 1);
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 4'b0010, "t2_grant");
            step(4'b1111, 4'b0100, "t2_grant");
            step(4'b1111, 4'b1000, "t2_grant");
            step(4'b1111, 4'b0001, "t2_grant");
        end
        step(4'b0000, 4'b0000, "t2_stop");
        wait_idle("t2_idle");

        // Consumer stalled: exactly FIFO_DEPTH accepts, head holds.
        rsp_ready = 1'b0;
        step(4'b1111, 4'b0010, "t3_grant");
        step(4'b1111, 4'b0100, "t3_grant");
        step(4'b1111, 4'b1000, "t3_grant");
        step(4'b1111, 4'b0001, "t3_grant");
        step(4'b1111, 4'b0000, "t3_full");
        chk("t3_head_valid", longint'(rsp_valid), 1);
        chk("t3_head_id",    longint'(rsp_id),    1);
        chk("t3_head_count", longint'(rsp_count), 512);
        step(4'b1111, 4'b0000, "t3_full");
        chk("t3_head_id2",    longint'(rsp_id),    1);
        chk("t3_head_count2", longint'(rsp_count), 512);
        rsp_ready = 1'b1;
        step(4'b1111, 4'b0010, "t3_release");
        step(4'b1111, 4'b0100, "t3_release");
        step(4'b1111, 4'b1000, "t3_release");
        step(4'b1111, 4'b0001, "t3_release");
        step(4'b0000, 4'b0000, "t3_stop");
        wait_idle("t3_idle");

        // Reduction boundaries.
        set_req(0, 15'h0000, 1'b0, 0,   0);
        set_req(1, 15'h2000, 1'b1, 0,   512);
        set_req(2, 15'h3001, 1'b1, 1,   511);
        set_req(3, 15'h11FF, 1'b1, 511, 1);
        step(4'b0001, 4'b0001, "t4_grant");
        step(4'b0010, 4'b0010, "t4_grant");
        step(4'b0100, 4'b0100, "t4_grant");
        step(4'b1000, 4'b1000, "t4_grant");
        step(4'b0000, 4'b0000, "t4_stop");
        wait_idle("t4_idle");

        // Reset with two FIFO entries plus S1 occupied.
        set_req(0, 15'h1005, 1'b1, 5,   1);
        set_req(1, 15'h2000, 1'b1, 0,   512);
        set_req(2, 15'h3100, 1'b1, 256, 256);
        rsp_ready = 1'b0;
        step(4'b0111, 4'b0001, "t5_grant");
        step(4'b0111, 4'b0010, "t5_grant");
        step(4'b0111, 4'b0100, "t5_grant");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_busy_pre",   longint'(busy),      1);
        chk("t5_ready_rst",  longint'(req_ready), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("t5_rsp_valid", longint'(rsp_valid), 0);
        chk("t5_busy",      longint'(busy),      0);
        chk("t5_chk_code",  longint'(chk_code),  0);
        step(4'b1111, 4'b0001, "t5_ptr0");
        step(4'b0000, 4'b0000, "t5_stop");
        wait_idle("t5_idle");

        // Lone requester back-to-back, then pointer favours req3 over req0.
        set_req(0, 15'h3100, 1'b1, 256, 256);
        set_req(2, 15'h1123, 1'b1, 291, 1);
        set_req(3, 15'h11FF, 1'b1, 511, 1);
        step(4'b0100, 4'b0100, "t6_b2b");
        step(4'b0100, 4'b0100, "t6_b2b");
        step(4'b0100, 4'b0100, "t6_b2b");
        step(4'b1001, 4'b1000, "t6_ptr3");
        step(4'b1001, 4'b0001, "t6_next");
        step(4'b0000, 4'b0000, "t6_stop");
        wait_idle("t6_idle");

        chk("sb_empty", longint'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
